output_port_alloc: RTL and testbench
====================================

# output_port_alloc

Per-output-port allocator and crossbar stage of the NoC router. One instance sits downstream of the P input queues for each output port. It collects the request bit for its port from every input queue and arbitrates round-robin. It returns a one-cycle registered grant, muxes the granted input's held flit onto the output link, and tracks downstream buffer space with a credit counter.

## Interface
- FW, 64: flit width.
- P, 7: number of router ports (inputs competing for this output).
- B, 4: downstream buffer address width; downstream depth is DEPTH = 2**B flits.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  P  bit i = input queue i requests this output (its dest_port_req bit for this port).
- flit_in  input  P*FW  flit_to_crossbar of input i at bits [i*FW +: FW].
- grant  output  P  one-hot or zero; bit i = this output granted to input i (its grant_dest_port bit).
- credit_in  input  1  one-cycle pulse: downstream released one buffer slot (its flit_rel).
- flit_out_wr  output  1  flit_out valid this cycle (drives downstream flit_in_wr).
- flit_out  output  FW  flit to downstream link.
- credit_cnt  output  B+1  free downstream slots, 0..DEPTH.
- cred_err  output  1  sticky: credit_in received while credit_cnt == DEPTH.

## Operation
- Reset values: grant = 0, flit_out_wr = 0, flit_out = 0, credit_cnt = DEPTH, cred_err = 0, rr pointer = 0, no transfer pending.
- Eligible mask each cycle is req AND NOT grant. An input already holding a grant this cycle is excluded, which breaks the combinational req/grant dependency inside the input queue.
- Arbitration happens when the eligible mask is nonzero and credit_cnt > 0.
  - Search starts at index ptr, increasing, and wraps from P-1 to 0. The first eligible index w wins.
  - grant <= one-hot(w) on the next edge.
  - ptr <= (w == P-1) ? 0 : w+1.
- No winner, or credit_cnt == 0: grant <= 0 and ptr is unchanged.
- Transfer: in a cycle with grant[i] = 1, flit_in[i] is captured. On the next edge flit_out <= flit_in[i] and flit_out_wr <= 1; otherwise flit_out_wr <= 0. flit_out holds its last value when idle.
- Credit update per edge:
  - Decrement by 1 when a grant is issued.
  - Increment by 1 on credit_in.
  - Both in the same cycle: no net change.
  - credit_in with credit_cnt == DEPTH and no decrement: count stays DEPTH and cred_err <= 1. cred_err clears only on rst.
- Credits are consumed at grant issue, so the count never underflows. No grant is issued at credit_cnt == 0.
- Multicast is handled by the input queue requesting several outputs. Each output allocator acts independently.

## Timing
- Cycle t: req[i] sampled high, credit_cnt > 0, i wins.
- Cycle t+1: grant[i] = 1 for exactly one cycle and credit_cnt shows the decrement. The input queue presents the held flit on flit_in[i] and drops req[i].
- Cycle t+2: flit_out_wr = 1 with that flit.
- Back-to-back: a different eligible input can be arbitrated in cycle t+1 and granted in t+2. Sustained throughput is one flit per cycle while at least two inputs alternate and credits remain.
- A single input re-requesting continuously gets at most one grant every 2 cycles.
- Credit returned at cycle t (credit_in) is usable for arbitration at t+1.
- rst asserted mid-transfer: grant, flit_out_wr and the pending capture clear immediately (async), and credit_cnt returns to DEPTH. No flit is emitted after reset deasserts until a new grant.

## Test plan
- Reset, then req = 7'b0000100 for one cycle → grant = 7'b0000100 one cycle later, flit_out_wr pulse the cycle after with flit_out = flit_in[2], credit_cnt 16 → 15.
- req = 7'b1000001 held, fairness check → grants alternate 0,6,0,6 on consecutive cycles (input excluded while granted). No input is granted twice in a row while the other requests.
- Credit exhaustion: B = 4, req[3] continuous, no credit_in → exactly 16 grants, then grant stays 0 with credit_cnt = 0. One credit_in pulse → exactly one more grant.
- Simultaneous grant issue and credit_in at credit_cnt = 5 → credit_cnt stays 5.
- credit_in pulse at credit_cnt = 16 with no requests → credit_cnt stays 16, cred_err = 1 and stays set until rst.
- Assert rst the cycle grant[1] = 1 → grant, flit_out_wr = 0, credit_cnt = 16. No flit_out_wr pulse follows, and the pointer restarts at 0 (req = 7'b1111111 → first grant to input 0).

Source files
------------

// File: rtl/output_port_alloc_if.sv
// Output-port allocator link bundle.
// Groups the request/grant handshake from the input queues, the crossbar
// flit lanes, the downstream link and the credit/status outputs.
//   req         P     per-input request for this output
//   flit_in     P*FW  held flit of input i at [i*FW +: FW]
//   grant       P     registered one-hot (or zero) grant
//   credit_in   1     downstream slot released
//   flit_out_wr 1     flit_out valid
//   flit_out    FW    flit to downstream link
//   credit_cnt  B+1   free downstream slots
//   cred_err    1     sticky credit overflow
// slave  = the allocator, master = input queues + downstream side.
interface output_port_alloc_if #(
  parameter int FW = 64,
  parameter int P  = 7,
  parameter int B  = 4
);
  logic [P-1:0]    req;
  logic [P*FW-1:0] flit_in;
  logic [P-1:0]    grant;
  logic            credit_in;
  logic            flit_out_wr;
  logic [FW-1:0]   flit_out;
  logic [B:0]      credit_cnt;
  logic            cred_err;

  modport slave (
    input  req, flit_in, credit_in,
    output grant, flit_out_wr, flit_out, credit_cnt, cred_err
  );

  modport master (
    output req, flit_in, credit_in,
    input  grant, flit_out_wr, flit_out, credit_cnt, cred_err
  );
endinterface

// File: rtl/output_port_alloc.sv
// Per-output-port round-robin allocator and crossbar mux.
// Arbitrates among input queues requesting this output, issues a one-cycle
// registered grant, forwards the granted input's flit one cycle later and
// tracks downstream buffer space with a credit counter.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  output_port_alloc_if.slave (req/flit_in/credit_in in,
//        grant/flit_out_wr/flit_out/credit_cnt/cred_err out)
module output_port_alloc #(
  parameter int FW = 64,
  parameter int P  = 7,
  parameter int B  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output_port_alloc_if.slave    bus
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [B:0] DEPTH = (B+1)'(1) << B;

  logic [PW-1:0] ptr;
  logic [P-1:0]  elig;
  logic          win_valid;
  logic [PW-1:0] win_idx;
  logic [PW:0]   idx;
  logic [FW-1:0] sel_flit;

  // An input holding a grant this cycle is excluded so the queue can drop
  // req combinationally without a loop through the grant.
  assign elig = bus.req & ~bus.grant;

  // Rotating priority search starting at ptr, wrapping at P-1.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < P; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(P))
        idx = idx - (PW+1)'(P);
      if (!win_valid && elig[idx[PW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
    // Credits are taken at grant time, so never grant into a full link.
    if (bus.credit_cnt == '0)
      win_valid = 1'b0;
  end

  // Grant is one-hot, so OR-ing the masked lanes selects the granted flit.
  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < P; i++)
      if (bus.grant[i])
        sel_flit = sel_flit | bus.flit_in[i*FW +: FW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant       <= '0;
      bus.flit_out_wr <= 1'b0;
      bus.flit_out    <= '0;
      bus.credit_cnt  <= DEPTH;
      bus.cred_err    <= 1'b0;
      ptr             <= '0;
    end else begin
      bus.grant <= win_valid ? (P'(1) << win_idx) : '0;
      if (win_valid)
        ptr <= (win_idx == PW'(P-1)) ? '0 : win_idx + PW'(1);

      bus.flit_out_wr <= |bus.grant;
      if (|bus.grant)
        bus.flit_out <= sel_flit;

      case ({win_valid, bus.credit_in})
        2'b10: bus.credit_cnt <= bus.credit_cnt - (B+1)'(1);
        2'b01: begin
          if (bus.credit_cnt == DEPTH)
            bus.cred_err <= 1'b1;
          else
            bus.credit_cnt <= bus.credit_cnt + (B+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_alloc.sv
// Self-checking bench for output_port_alloc: directed steps from the test
// plan followed by a randomized phase, all checked against a cycle-level
// behavioural model of the allocation rules.
module tb_output_port_alloc;
  localparam int FW = 64;
  localparam int P  = 7;
  localparam int B  = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_port_alloc_if #(.FW(FW), .P(P), .B(B)) pif ();

  output_port_alloc #(.FW(FW), .P(P), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state: granted input (-1 = none), pointer, credits, flags
  int          m_g;
  int          m_ptr;
  int          m_cred;
  bit          m_err;
  bit          m_wr;
  logic [63:0] m_flit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_cred = DEPTH; m_err = 0; m_wr = 0; m_flit = '0;
  endtask

  // One clock edge worth of the allocation rules.
  task automatic model_step();
    int win;
    int i;
    win = -1;
    if (m_cred > 0)
      for (int d = 0; d < P; d++) begin
        i = (m_ptr + d) % P;
        if (win < 0 && pif.req[i] && (m_g != i)) win = i;
      end
    m_wr = (m_g >= 0);
    if (m_g >= 0) m_flit = pif.flit_in[m_g*FW +: FW];
    m_cred = m_cred + int'(pif.credit_in) - ((win >= 0) ? 1 : 0);
    if (m_cred > DEPTH) begin
      m_cred = DEPTH;
      m_err  = 1;
    end
    if (win >= 0) m_ptr = (win + 1) % P;
    m_g = win;
  endtask

  task automatic check_all();
    logic [63:0] eg;
    eg = (m_g >= 0) ? (64'd1 << m_g) : 64'd0;
    chk("grant", 64'(pif.grant), eg);
    chk("flit_out_wr", 64'(pif.flit_out_wr), 64'(m_wr));
    chk("flit_out", pif.flit_out, m_flit);
    chk("credit_cnt", 64'(pif.credit_cnt), 64'(m_cred));
    chk("cred_err", 64'(pif.cred_err), 64'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic refill();
    pif.req = '0;
    for (int n = 0; n < 2*DEPTH && m_cred < DEPTH; n++) begin
      pif.credit_in = 1'b1;
      cycle();
    end
    pif.credit_in = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount;
    int prev;
    int cur;
    logic [63:0] f2;

    pif.req = '0;
    pif.flit_in = '0;
    pif.credit_in = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(pif.grant), 64'd0);
    chk("rst_wr", 64'(pif.flit_out_wr), 64'd0);
    chk("rst_flit", pif.flit_out, 64'd0);
    chk("rst_credit", 64'(pif.credit_cnt), 64'd16);
    chk("rst_err", 64'(pif.cred_err), 64'd0);

    // single request from input 2
    pif.req = 7'b0000100;
    cycle();
    chk("single_grant", 64'(pif.grant), 64'h4);
    chk("single_credit", 64'(pif.credit_cnt), 64'd15);
    f2 = {$urandom, $urandom};
    pif.req = '0;
    pif.flit_in[2*FW +: FW] = f2;
    cycle();
    chk("single_wr", 64'(pif.flit_out_wr), 64'd1);
    chk("single_flit", pif.flit_out, f2);
    cycle();

    // fairness between inputs 0 and 6
    pif.req = 7'b1000001;
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < P; k++) pif.flit_in[k*FW +: FW] = {$urandom, $urandom};
      cycle();
      cur = -1;
      for (int k = 0; k < P; k++) if (pif.grant[k]) cur = k;
      chk("fair_granted", 64'(cur >= 0), 64'd1);
      if (prev >= 0) chk("fair_alternate", 64'(cur == prev), 64'd0);
      prev = cur;
    end
    refill();

    // credit exhaustion on input 3
    pif.req = 7'b0001000;
    gcount = 0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (pif.grant[3]) gcount++;
    end
    chk("exhaust_grants", 64'(gcount), 64'd16);
    chk("exhaust_credit", 64'(pif.credit_cnt), 64'd0);
    pif.credit_in = 1'b1;
    cycle();
    pif.credit_in = 1'b0;
    gcount = 0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      if (pif.grant[3]) gcount++;
    end
    chk("one_more_grant", 64'(gcount), 64'd1);

    // simultaneous grant and credit return at 5
    pif.req = '0;
    cycle();
    for (int n = 0; n < 5; n++) begin
      pif.credit_in = 1'b1;
      cycle();
    end
    pif.credit_in = 1'b0;
    cycle();
    chk("pre5_credit", 64'(pif.credit_cnt), 64'd5);
    pif.req = 7'b0000001;
    pif.credit_in = 1'b1;
    cycle();
    chk("simul_grant", 64'(pif.grant), 64'h1);
    chk("simul_credit", 64'(pif.credit_cnt), 64'd5);
    pif.credit_in = 1'b0;
    pif.req = '0;
    cycle();

    // overflow sets sticky error
    refill();
    chk("full_credit", 64'(pif.credit_cnt), 64'd16);
    pif.credit_in = 1'b1;
    cycle();
    pif.credit_in = 1'b0;
    chk("ovf_credit", 64'(pif.credit_cnt), 64'd16);
    chk("ovf_err", 64'(pif.cred_err), 64'd1);
    for (int n = 0; n < 4; n++) cycle();
    chk("ovf_err_sticky", 64'(pif.cred_err), 64'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      pif.req = 7'($urandom_range(0, 127));
      pif.credit_in = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < P; k++) pif.flit_in[k*FW +: FW] = {$urandom, $urandom};
      cycle();
    end

    // reset while grant[1] is high
    refill();
    pif.req = 7'b0000010;
    cycle();
    chk("pre_rst_grant", 64'(pif.grant), 64'h2);
    pif.req = '0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_grant", 64'(pif.grant), 64'd0);
    chk("midrst_wr", 64'(pif.flit_out_wr), 64'd0);
    chk("midrst_credit", 64'(pif.credit_cnt), 64'd16);
    chk("midrst_err", 64'(pif.cred_err), 64'd0);
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("post_rst_no_wr", 64'(pif.flit_out_wr), 64'd0);
    end
    pif.req = 7'b1111111;
    cycle();
    chk("post_rst_first", 64'(pif.grant), 64'h1);
    pif.req = '0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
